// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and types for the 4-channel arbitrating mux.
//   NUM_CH       - number of source channels
//   TAG_W        - width of the source tag {S1,S0}
//   lock_state_e - burst-lock FSM states (used when MUX_ARB_LOCK_EN is defined)
package mux_arb_pkg;
  localparam int NUM_CH = 4;
  localparam int TAG_W  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;
endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: combinational round-robin picker over four valid bits.
// Searches ptr+1, ptr+2, ptr+3, ptr (mod 4); the first valid index wins.
//   valid_i - per-channel request mask
//   ptr_i   - index of the most recently granted channel
//   gnt_o   - winning channel index (ptr_i when nothing is valid)
//   any_o   - at least one channel is valid
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] valid_i,
  input  logic [TAG_W-1:0]  ptr_i,
  output logic [TAG_W-1:0]  gnt_o,
  output logic              any_o
);

  logic [TAG_W-1:0] idx;

  always_comb begin
    gnt_o = ptr_i;
    any_o = 1'b0;
    idx   = '0;
    // k = NUM_CH wraps back to ptr itself, so the last winner is tried last
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = ptr_i + TAG_W'(k);
      if (!any_o && valid_i[idx]) begin
        gnt_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_4.sv
// mux_arb_4: four-channel round-robin arbitrating multiplexer with one
// registered output stage. Each output byte carries its source index on
// {out_s1_o, out_s0_o} and a registered copy of the source's last bit.
// Optional feature: define MUX_ARB_LOCK_EN to hold the grant on one channel
// from its first non-last byte until its last byte (burst lock).
//   clk_i, rst_n_i        - clock, synchronous active-low reset
//   in_valid_i[3:0]       - per-channel valid
//   in_data0_i..3_i       - per-channel data
//   in_last_i[3:0]        - per-channel end-of-burst marker
//   in_ready_o[3:0]       - per-channel ready (at most one bit set)
//   out_valid_o/out_ready_i, out_data_o, out_s0_o, out_s1_o, out_last_o
module mux_arb_4
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NUM_CH-1:0] in_valid_i,
  input  logic [WIDTH-1:0]  in_data0_i,
  input  logic [WIDTH-1:0]  in_data1_i,
  input  logic [WIDTH-1:0]  in_data2_i,
  input  logic [WIDTH-1:0]  in_data3_i,
  input  logic [NUM_CH-1:0] in_last_i,
  output logic [NUM_CH-1:0] in_ready_o,
  output logic              out_valid_o,
  output logic [WIDTH-1:0]  out_data_o,
  output logic              out_s0_o,
  output logic              out_s1_o,
  output logic              out_last_o,
  input  logic              out_ready_i
);

  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] pick_gnt, gnt;
  logic             pick_any, any;
  logic             load, xfer;
  logic [WIDTH-1:0] sel_data;

  logic             vld_q;
  logic [WIDTH-1:0] data_q;
  logic [TAG_W-1:0] tag_q;
  logic             last_q;

  rr_pick_4 u_pick (
    .valid_i (in_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .any_o   (pick_any)
  );

  // Output register can take a new byte when empty or being drained now
  assign load = ~vld_q | out_ready_i;

`ifdef MUX_ARB_LOCK_EN
  lock_state_e      state_q, state_d;
  logic [TAG_W-1:0] lock_ch_q, lock_ch_d;

  // While locked, only the owning channel may transfer, even if it is idle
  always_comb begin
    gnt = pick_gnt;
    any = pick_any;
    if (state_q == LOCKED) begin
      gnt = lock_ch_q;
      any = in_valid_i[lock_ch_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      if (state_q == IDLE && !in_last_i[gnt]) begin
        state_d   = LOCKED;
        lock_ch_d = gnt;
      end else if (state_q == LOCKED && in_last_i[gnt]) begin
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  assign gnt = pick_gnt;
  assign any = pick_any;
`endif

  // Gating with reset keeps ready low during reset so no source sees a
  // handshake that the output register then throws away.
  assign xfer = any & load & rst_n_i;

  always_comb begin
    in_ready_o = '0;
    if (xfer) in_ready_o[gnt] = 1'b1;
  end

  always_comb begin
    case (gnt)
      2'd0:    sel_data = in_data0_i;
      2'd1:    sel_data = in_data1_i;
      2'd2:    sel_data = in_data2_i;
      default: sel_data = in_data3_i;
    endcase
  end

  // PTR resets to 3 so the first search starts at channel 0
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
      last_q <= 1'b0;
      ptr_q  <= 2'd3;
    end else if (xfer) begin
      vld_q  <= 1'b1;
      data_q <= sel_data;
      tag_q  <= gnt;
      last_q <= in_last_i[gnt];
      ptr_q  <= gnt;
    end else if (load) begin
      vld_q  <= 1'b0;
    end
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;
  assign out_s0_o    = tag_q[0];
  assign out_s1_o    = tag_q[1];
  assign out_last_o  = last_q;

endmodule
